// File: rtl/regfile_writeback_queue_pkg.sv
// regfile_writeback_queue_pkg
//   Shared definitions for the register-file writeback queue: register file
//   geometry and the packed entry type carried through the queue.
package regfile_writeback_queue_pkg;

  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 16;

  // One pending register-file write: destination index plus result data.
  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_wb_fifo_2w1r.sv
// wb_fifo_2w1r
//   Two-write, one-read FIFO of wb_entry_t. When both write ports fire in the
//   same cycle, wr0 is stored ahead of wr1. The caller guarantees it never
//   writes more than the free space and never reads when empty.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr0_en, wr0_entry   first (older) write port
//   wr1_en, wr1_entry   second (younger) write port
//   rd_en               pop the head this cycle
//   rd_entry            current head entry (combinational from storage)
//   count               current occupancy
module wb_fifo_2w1r
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr0_en,
  input  wb_entry_t        wr0_entry,
  input  logic             wr1_en,
  input  wb_entry_t        wr1_entry,
  input  logic             rd_en,
  output wb_entry_t        rd_entry,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (wr0_en || wr1_en) begin
      // A lone write always lands in the first free slot, whichever port.
      mem_d[wr_ptr_q] = wr0_en ? wr0_entry : wr1_entry;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      if (wr0_en && wr1_en) begin
        mem_d[wr_ptr_d] = wr1_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_d);
      end
    end
    rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(rd_en);
  end

  // Storage holds no state that matters after reset, so it is not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_entry = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
//   Writeback-side driver for the 16x16 register file write port. Accepts
//   load and ALU results over valid/ready, buffers them in arrival order
//   (load ahead of ALU when simultaneous) and retires one per cycle onto a
//   registered WriteReg/DstReg/DstData output stage.
// Optional feature macro: REGFILE_WB_BUSY_EN builds per-register in-flight
//   counters driving busy; without it busy is tied to zero.
// Ports:
//   clk, rst_n                              clock, async active-low reset
//   mem_valid/mem_ready/mem_reg/mem_data    load result handshake
//   alu_valid/alu_ready/alu_reg/alu_data    ALU result handshake
//   WriteReg, DstReg, DstData               registered register-file write
//   busy                                    per-register write-in-flight flag
//   fifo_count                              queue occupancy (excl. output)
module regfile_writeback_queue
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [REG_IDX_W-1:0] mem_reg,
  input  logic [DATA_W-1:0]    mem_data,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_reg,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 WriteReg,
  output logic [REG_IDX_W-1:0] DstReg,
  output logic [DATA_W-1:0]    DstData,
  output logic [NUM_REGS-1:0]  busy,
  output logic [CNT_W-1:0]     fifo_count
);

  wb_entry_t        mem_entry, alu_entry, head;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_plus_mem;
  logic             push_mem, push_alu, pop;

  assign mem_entry.idx  = mem_reg;
  assign mem_entry.data = mem_data;
  assign alu_entry.idx  = alu_reg;
  assign alu_entry.data = alu_data;

  // Readies look only at the registered count (a same-cycle pop does not
  // help), and the ALU side reserves a slot for an offered load, which keeps
  // alu_valid out of every ready path.
  assign count_plus_mem = {1'b0, count} + {{CNT_W{1'b0}}, mem_valid};
  assign mem_ready      = ({1'b0, count} < (CNT_W + 1)'(DEPTH));
  assign alu_ready      = (count_plus_mem < (CNT_W + 1)'(DEPTH));
  assign push_mem       = mem_valid && mem_ready;
  assign push_alu       = alu_valid && alu_ready;
  assign pop            = (count != '0);

  wb_fifo_2w1r #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr0_en    (push_mem),
    .wr0_entry (mem_entry),
    .wr1_en    (push_alu),
    .wr1_entry (alu_entry),
    .rd_en     (pop),
    .rd_entry  (head),
    .count     (count)
  );

  // Output stage: reloads every cycle; index/data hold when nothing retires.
  logic                 wr_en_q, wr_en_d;
  logic [REG_IDX_W-1:0] dst_reg_q, dst_reg_d;
  logic [DATA_W-1:0]    dst_data_q, dst_data_d;

  always_comb begin
    wr_en_d    = pop;
    dst_reg_d  = dst_reg_q;
    dst_data_d = dst_data_q;
    if (pop) begin
      dst_reg_d  = head.idx;
      dst_data_d = head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q    <= 1'b0;
      dst_reg_q  <= '0;
      dst_data_q <= '0;
    end else begin
      wr_en_q    <= wr_en_d;
      dst_reg_q  <= dst_reg_d;
      dst_data_q <= dst_data_d;
    end
  end

  assign WriteReg   = wr_en_q;
  assign DstReg     = dst_reg_q;
  assign DstData    = dst_data_q;
  assign fifo_count = count;

`ifdef REGFILE_WB_BUSY_EN
  // Per-register count of writes queued or sitting in the output stage.
  // Worst case is DEPTH queued plus one retiring, hence DEPTH+2 codes.
  localparam int BUSY_W = $clog2(DEPTH + 2);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    logic [BUSY_W-1:0] cnt_q, cnt_d;
    logic [1:0]        inc;
    logic              dec;

    always_comb begin
      inc   = 2'(push_mem && (mem_reg == REG_IDX_W'(gi)))
            + 2'(push_alu && (alu_reg == REG_IDX_W'(gi)));
      // The output stage is replaced every edge, so a live write retires now.
      dec   = wr_en_q && (dst_reg_q == REG_IDX_W'(gi));
      cnt_d = cnt_q + BUSY_W'(inc) - BUSY_W'(dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign busy[gi] = (cnt_q != '0);
  end
`else
  assign busy = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue
//   Self-checking bench: a queue-based reference model of the writeback
//   queue is compared against the DUT every cycle, with directed scenarios
//   pinned by literal expectations and a long randomized run.
//   Build with REGFILE_WB_BUSY_EN defined to expect live busy flags.
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef REGFILE_WB_BUSY_EN
  localparam bit BUSY_ON = 1'b1;
`else
  localparam bit BUSY_ON = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  idx;
    logic [15:0] data;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mem_valid, alu_valid;
  logic             mem_ready, alu_ready;
  logic [3:0]       mem_reg, alu_reg;
  logic [15:0]      mem_data, alu_data;
  logic             WriteReg;
  logic [3:0]       DstReg;
  logic [15:0]      DstData;
  logic [15:0]      busy;
  logic [CNT_W-1:0] fifo_count;

  regfile_writeback_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_reg    (mem_reg),
    .mem_data   (mem_data),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_reg    (alu_reg),
    .alu_data   (alu_data),
    .WriteReg   (WriteReg),
    .DstReg     (DstReg),
    .DstData    (DstData),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: pending writes in order, plus the write being retired.
  ent_t        q[$];
  logic        m_we;
  logic [3:0]  m_dreg;
  logic [15:0] m_ddata;
  logic [15:0] wr_log[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_busy();
    logic [15:0] b;
    b = '0;
    if (BUSY_ON) begin
      foreach (q[i]) b[q[i].idx] = 1'b1;
      if (m_we) b[m_dreg] = 1'b1;
    end
    return b;
  endfunction

  task automatic model_reset();
    q.delete();
    m_we    = 1'b0;
    m_dreg  = '0;
    m_ddata = '0;
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic compare_outputs();
    chk("WriteReg", WriteReg, m_we);
    chk("DstReg", DstReg, m_dreg);
    chk("DstData", DstData, m_ddata);
    chk("fifo_count", fifo_count, 32'(q.size()));
    chk("busy", busy, exp_busy());
    chk("mem_ready", mem_ready, q.size() < DEPTH);
    chk("alu_ready", alu_ready, (q.size() + (mem_valid ? 1 : 0)) < DEPTH);
    if (WriteReg === 1'b1) wr_log.push_back(DstData);
  endtask

  // One clock: drive at negedge, compare, then advance model at posedge.
  task automatic cycle(input logic mv, input logic [3:0] mr, input logic [15:0] md,
                       input logic av, input logic [3:0] ar, input logic [15:0] ad,
                       output logic am, output logic aa,
                       output logic s_mr, output logic s_ar);
    ent_t e;
    @(negedge clk);
    mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    #1;
    compare_outputs();
    s_mr = mem_ready;
    s_ar = alu_ready;
    am = mv && (q.size() < DEPTH);
    aa = av && ((q.size() + (mv ? 1 : 0)) < DEPTH);
    @(posedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_dreg = e.idx; m_ddata = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (am) q.push_back({mr, md});
    if (aa) q.push_back({ar, ad});
  endtask

  task automatic idle(input int n);
    logic a, b, c, d;
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, a, b, c, d);
  endtask

  initial begin
    logic        am, aa, smr, sar;
    logic        pmv, pav;
    logic [3:0]  pmr, par;
    logic [15:0] pmd, pad;
    int          pm, pa;
    logic [15:0] exp_seq[6];

    rst_n = 1'b0;
    mem_valid = 0; alu_valid = 0; mem_reg = 0; alu_reg = 0; mem_data = 0; alu_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_WriteReg", WriteReg, 0);
    chk("rst_DstReg", DstReg, 0);
    chk("rst_DstData", DstData, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_alu_ready", alu_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single load r3 = BEEF.
    cycle(1, 4'd3, 16'hBEEF, 0, 0, 0, am, aa, smr, sar);
    #1;
    chk("t1_count_e1", fifo_count, 1);
    chk("t1_we_e1", WriteReg, 0);
    chk("t1_busy3_e1", busy[3], BUSY_ON);
    idle(1);
    #1;
    chk("t1_we_e2", WriteReg, 1);
    chk("t1_dreg_e2", DstReg, 3);
    chk("t1_data_e2", DstData, 16'hBEEF);
    chk("t1_busy3_e2", busy[3], BUSY_ON);
    idle(1);
    #1;
    chk("t1_we_e3", WriteReg, 0);
    chk("t1_busy_e3", busy, 0);

    // Simultaneous load and ALU to r5: load retires first.
    cycle(1, 4'd5, 16'h1111, 1, 4'd5, 16'h2222, am, aa, smr, sar);
    #1;
    chk("t2_count", fifo_count, 2);
    idle(1);
    #1;
    chk("t2_first", DstData, 16'h1111);
    chk("t2_busy5_a", busy[5], BUSY_ON);
    idle(1);
    #1;
    chk("t2_second", DstData, 16'h2222);
    chk("t2_dreg", DstReg, 5);
    chk("t2_busy5_b", busy[5], BUSY_ON);
    idle(1);
    #1;
    chk("t2_we_end", WriteReg, 0);
    chk("t2_busy_end", busy, 0);

    // Backpressure: two pushes per cycle until the ALU is held off.
    wr_log.delete();
    cycle(1, 4'd1, 16'hA000, 1, 4'd2, 16'hB000, am, aa, smr, sar);
    cycle(1, 4'd3, 16'hA001, 1, 4'd4, 16'hB001, am, aa, smr, sar);
    cycle(1, 4'd5, 16'hA002, 1, 4'd6, 16'hB002, am, aa, smr, sar);
    chk("t3_mem_ready_at3", smr, 1);
    chk("t3_alu_ready_at3", sar, 0);
    cycle(0, 4'd0, 16'h0, 1, 4'd6, 16'hB002, am, aa, smr, sar);
    chk("t3_alu_taken_late", aa, 1);
    idle(8);
    exp_seq = '{16'hA000, 16'hB000, 16'hA001, 16'hB001, 16'hA002, 16'hB002};
    chk("t3_write_count", wr_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < wr_log.size()) chk("t3_order", wr_log[i], exp_seq[i]);
    #1;
    chk("t4_drained_count", fifo_count, 0);
    chk("t4_drained_we", WriteReg, 0);

    // Reset with entries still queued.
    cycle(1, 4'd7, 16'h7777, 1, 4'd8, 16'h8888, am, aa, smr, sar);
    cycle(1, 4'd9, 16'h9999, 1, 4'd10, 16'hAAAA, am, aa, smr, sar);
    #1;
    chk("t5_count_before", fifo_count, 3);
    @(negedge clk);
    mem_valid = 0; alu_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_we", WriteReg, 0);
    chk("t5_rst_dreg", DstReg, 0);
    chk("t5_rst_data", DstData, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_count", fifo_count, 0);
    chk("t5_rst_mem_ready", mem_ready, 1);
    chk("t5_rst_alu_ready", alu_ready, 1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wr_log.delete();
    idle(5);
    chk("t5_no_stale_writes", wr_log.size(), 0);

    // Randomized run with phases of heavy, medium and light offered load.
    pmv = 0; pav = 0; pmr = 0; par = 0; pmd = 0; pad = 0;
    for (int c = 0; c < 3000; c++) begin
      case ((c / 250) % 3)
        0:       begin pm = 90; pa = 90; end
        1:       begin pm = 50; pa = 60; end
        default: begin pm = 15; pa = 20; end
      endcase
      if (!pmv) begin
        pmv = ($urandom_range(0, 99) < pm);
        pmr = 4'($urandom_range(0, 5));
        pmd = 16'($urandom);
      end
      if (!pav) begin
        pav = ($urandom_range(0, 99) < pa);
        par = 4'($urandom_range(0, 5));
        pad = 16'($urandom);
      end
      cycle(pmv, pmr, pmd, pav, par, pad, am, aa, smr, sar);
      if (am) pmv = 0;
      if (aa) pav = 0;
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
